// File: rtl/md_unit_ctrl_if.sv
// Handshake/bus bundle between the E-stage issue logic and the multiply/divide unit.
// The cancel wire exists only when MDU_CANCEL_EN is defined.
interface md_unit_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_md_use;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  modport slave (
`ifdef MDU_CANCEL_EN
    input  cancel,
`endif
    input  start,
    input  md_op,
    input  rs_data,
    input  rt_data,
    input  d_md_use,
    output busy,
    output md_stall,
    output hi,
    output lo
  );

  modport master (
`ifdef MDU_CANCEL_EN
    output cancel,
`endif
    output start,
    output md_op,
    output rs_data,
    output rt_data,
    output d_md_use,
    input  busy,
    input  md_stall,
    input  hi,
    input  lo
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer holding HI/LO; models mult/div latency with a busy counter.
// Optional abort of the in-flight op is enabled by defining MDU_CANCEL_EN.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_unit_ctrl_if.slave  md
);

  localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] p_hi_reg, p_hi_next;
  logic [31:0] p_lo_reg, p_lo_next;

  logic is_mul, is_div, is_long, is_mthi, is_mtlo;
  logic cancel_req;

  always_comb begin
    is_mul  = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
    is_div  = (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
    is_long = is_mul || is_div;
    is_mthi = (md.md_op == OP_MTHI);
    is_mtlo = (md.md_op == OP_MTLO);
  end

`ifdef MDU_CANCEL_EN
  assign cancel_req = md.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  // Products are formed on full 64-bit operands so the high word is exact.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{md.rs_data[31]}}, md.rs_data}) *
                  $signed({{32{md.rt_data[31]}}, md.rt_data});
  assign prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};

  // Signed divide runs on 33 bits so 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
  logic               div_by_zero;
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic        [31:0] dvs_u, quo_u, rem_u;

  assign div_by_zero = (md.rt_data == 32'd0);
  assign dvd_s = $signed({md.rs_data[31], md.rs_data});
  assign dvs_s = div_by_zero ? 33'sd1 : $signed({md.rt_data[31], md.rt_data});
  assign quo_s = dvd_s / dvs_s;
  assign rem_s = dvd_s % dvs_s;
  assign dvs_u = div_by_zero ? 32'd1 : md.rt_data;
  assign quo_u = md.rs_data / dvs_u;
  assign rem_u = md.rs_data % dvs_u;

  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_hi = hi_reg;
    res_lo = lo_reg;
    case (md.md_op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (!div_by_zero) begin
          res_hi = rem_s[31:0];
          res_lo = quo_s[31:0];
        end
      end
      OP_DIVU: begin
        if (!div_by_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin
        res_hi = hi_reg;
        res_lo = lo_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      p_hi_reg  <= 32'd0;
      p_lo_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      p_hi_reg  <= p_hi_next;
      p_lo_reg  <= p_lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    p_hi_next  = p_hi_reg;
    p_lo_next  = p_lo_reg;
    case (state_reg)
      IDLE: begin
        if (md.start && !cancel_req) begin
          if (is_long) begin
            p_hi_next  = res_hi;
            p_lo_next  = res_lo;
            cnt_next   = is_div ? DIV_CNT : MULT_CNT;
            state_next = BUSY;
          end else if (is_mthi) begin
            hi_next = md.rs_data;
          end else if (is_mtlo) begin
            lo_next = md.rs_data;
          end
        end
      end
      BUSY: begin
        // Abort wins over the commit edge; new starts are never accepted here.
        if (cancel_req) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
          p_hi_next  = 32'd0;
          p_lo_next  = 32'd0;
        end else begin
          cnt_next = cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) begin
            hi_next    = p_hi_reg;
            lo_next    = p_lo_reg;
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  assign md.busy     = (state_reg == BUSY);
  assign md.md_stall = md.d_md_use & ((state_reg == BUSY) | (md.start & is_long));
  assign md.hi       = hi_reg;
  assign md.lo       = lo_reg;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: expected HI/LO/latency queued at issue, compared when busy drops.
// Define MDU_CANCEL_EN for both RTL and bench to exercise the cancel path.
module tb_md_unit_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_unit_ctrl_if mif ();

  md_unit_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference arithmetic done in 64-bit two-state integers.
  task automatic model_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output logic [31:0] eh, output logic [31:0] el, output int ec);
    longint a, b, p;
    logic [63:0] pu;
    eh = cur_hi;
    el = cur_lo;
    ec = 0;
    case (op)
      3'd1: begin
        a = longint'(int'(rs));
        b = longint'(int'(rt));
        p = a * b;
        eh = p[63:32];
        el = p[31:0];
        ec = 5;
      end
      3'd2: begin
        pu = {32'd0, rs} * {32'd0, rt};
        eh = pu[63:32];
        el = pu[31:0];
        ec = 5;
      end
      3'd3: begin
        ec = 10;
        if (rt != 0) begin
          a = longint'(int'(rs));
          b = longint'(int'(rt));
          el = 32'(a / b);
          eh = 32'(a % b);
        end
      end
      3'd4: begin
        ec = 10;
        if (rt != 0) begin
          el = rs / rt;
          eh = rs % rt;
        end
      end
      3'd5: eh = rs;
      3'd6: el = rs;
      default: ec = 0;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] eh, input logic [31:0] el, input int ec,
                       input bit use_d = 1'b0, input int inject_at = 0, input int cancel_at = 0);
    exp_t e;
    int   n;
    bit   done;
    e.hi = eh;
    e.lo = el;
    e.cycles = ec;
    sb_q.push_back(e);

    @(negedge clk);
    mif.start    = 1'b1;
    mif.md_op    = op;
    mif.rs_data  = rs;
    mif.rt_data  = rt;
    mif.d_md_use = use_d;
    #1;
    if (use_d) check("stall_start", {63'd0, mif.md_stall}, {63'd0, (op >= 3'd1 && op <= 3'd4)});
    @(posedge clk);
    #1;
    mif.start   = 1'b0;
    mif.md_op   = 3'd0;
    mif.rs_data = $urandom;
    mif.rt_data = $urandom;

    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      mif.start = 1'b0;
      mif.md_op = 3'd0;
`ifdef MDU_CANCEL_EN
      mif.cancel = 1'b0;
`endif
      if (!mif.busy) begin
        done = 1'b1;
      end else begin
        n++;
        if (use_d) check("stall_busy", {63'd0, mif.md_stall}, 64'd1);
        if (n == inject_at) begin
          mif.start   = 1'b1;
          mif.md_op   = 3'd3;
          mif.rs_data = 32'd100;
          mif.rt_data = 32'd7;
        end
`ifdef MDU_CANCEL_EN
        if (n == cancel_at) mif.cancel = 1'b1;
`endif
        if (n > 300) begin
          check("busy_timeout", 64'(n), 64'(ec));
          done = 1'b1;
        end
      end
    end

    e = sb_q.pop_front();
    check("busy_cycles", 64'(n), 64'(e.cycles));
    check("hi", {32'd0, mif.hi}, {32'd0, e.hi});
    check("lo", {32'd0, mif.lo}, {32'd0, e.lo});
    if (use_d) check("stall_after", {63'd0, mif.md_stall}, 64'd0);
    cur_hi = e.hi;
    cur_lo = e.lo;
    mif.d_md_use = 1'b0;
    $display("txn op=%0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d (cancel_at=%0d)",
             op, rs, rt, mif.hi, mif.lo, n, cancel_at);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs, rt, eh, el;
    logic [2:0]  op;
    int          ec;
    int          n;

    mif.start    = 1'b0;
    mif.md_op    = 3'd0;
    mif.rs_data  = 32'd0;
    mif.rt_data  = 32'd0;
    mif.d_md_use = 1'b0;
`ifdef MDU_CANCEL_EN
    mif.cancel   = 1'b0;
`endif
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, mif.busy}, 64'd0);
    check("rst_stall", {63'd0, mif.md_stall}, 64'd0);
    check("rst_hi", {32'd0, mif.hi}, 64'd0);
    check("rst_lo", {32'd0, mif.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    issue(3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    issue(3'd5, 32'h12345678, 32'd0, 32'h12345678, 32'd3, 0);
    issue(3'd4, 32'd55, 32'd0, 32'h12345678, 32'd3, 10);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
    issue(3'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5, 1'b1);
    issue(3'd6, 32'hCAFEBABE, 32'd0, 32'd0, 32'hCAFEBABE, 0);
    issue(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b0, 2);
    issue(3'd7, 32'd1, 32'd2, 32'd0, 32'd12, 0);
    issue(3'd0, 32'd9, 32'd9, 32'd0, 32'd12, 0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      rs = $urandom;
      rt = $urandom;
      if (rt == 32'd0) rt = 32'd3;
      model_op(op, rs, rt, eh, el, ec);
      issue(op, rs, rt, eh, el, ec);
    end

`ifdef MDU_CANCEL_EN
    issue(3'd1, 32'd9, 32'd9, cur_hi, cur_lo, 5, 1'b0, 0, 5);
    mif.cancel = 1'b1;
    issue(3'd5, 32'hDEADBEEF, 32'd0, cur_hi, cur_lo, 0);
`endif

    issue(3'd5, 32'hAAAA5555, 32'd0, 32'hAAAA5555, cur_lo, 0);
    issue(3'd6, 32'h5555AAAA, 32'd0, 32'hAAAA5555, 32'h5555AAAA, 0);

    // Reset pulse in the third busy cycle of a mult.
    @(negedge clk);
    mif.start   = 1'b1;
    mif.md_op   = 3'd1;
    mif.rs_data = 32'd5;
    mif.rt_data = 32'd5;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    n = 0;
    while (n < 3) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_pre_busy", {63'd0, mif.busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, mif.busy}, 64'd0);
    check("rst_mid_hi", {32'd0, mif.hi}, 64'd0);
    check("rst_mid_lo", {32'd0, mif.lo}, 64'd0);
    $display("txn reset mid-mult -> busy=%0d hi=%h lo=%h", mif.busy, mif.hi, mif.lo);
    @(negedge clk);
    reset = 1'b1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    issue(3'd2, 32'd2, 32'd3, 32'd0, 32'd6, 5, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multiply/divide sequencer for the pipelined MIPS datapath, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo issued from E and holds the architectural HI/LO registers. It models the multi-cycle latency with a busy counter and produces the stall request the hazard logic uses to freeze D when a multiply/divide-class instruction reaches D while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy length of mult/multu (1..255)
- DIV_CYCLES, 10, busy length of div/divu (1..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  E-stage instruction is a valid md op this cycle
- md_op  in  3  1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 0/7 = no-op
- rs_data  in  32  forwarded rs operand in E
- rt_data  in  32  forwarded rt operand in E
- d_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- md_stall  out  1  stall request to the hazard unit
- hi  out  32  architectural HI (feeds mfhi)
- lo  out  32  architectural LO (feeds mflo)
- cancel  in  1  only with MDU_CANCEL_EN; aborts the in-flight op

## Operation
- States: IDLE, BUSY. 8-bit down-counter cnt; pending registers p_hi, p_lo.
- IDLE, start=1, md_op in 1..4: compute the result from rs_data/rt_data, latch it into p_hi/p_lo, load cnt with MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - mult: signed 64-bit product {p_hi,p_lo}.
  - multu: unsigned 64-bit product.
  - div: p_lo = signed quotient truncated toward zero; p_hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - rt_data == 0 (div/divu): busy sequence runs normally; p_hi/p_lo are loaded with the current hi/lo, so HI/LO are unchanged.
  - div with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- IDLE, start=1, md_op=5: hi <= rs_data at that edge. md_op=6: lo <= rs_data. Stays IDLE; busy is never asserted.
- BUSY: cnt decrements each edge. On the edge where cnt==1, hi <= p_hi, lo <= p_lo, go to IDLE.
- start during BUSY (any op): ignored; the hazard unit guarantees this cannot happen.
- md_op 0/7 with start=1: no effect.
- md_stall = d_md_use & (busy | (start & md_op in 1..4)). Combinational.
- hi/lo change only at commit, on mthi/mtlo, or at reset.

## Timing
- Reset: state IDLE, cnt=0, hi=lo=p_hi=p_lo=0, busy=0, md_stall = 0 while d_md_use=0.
- start sampled at edge T. busy is high for exactly N cycles (T+1 through T+N edges). The new HI/LO become visible, and busy falls, right after edge T+N. An mfhi issued in the cycle busy=0 reads the new value.
- mthi/mtlo: zero busy cycles; the new value is visible the cycle after edge T.
- md_stall asserts in the start cycle itself, so the follower in D is held from cycle T onward.
- reset asserted mid-operation: immediate clear, and the pending result is lost.

## Configuration
- MDU_CANCEL_EN defined: the cancel port exists. cancel=1 in BUSY forces IDLE at the next edge with hi/lo unchanged and p_hi/p_lo discarded. cancel has priority over commit on the cnt==1 edge. cancel=1 in IDLE together with start ignores the start, including mthi/mtlo. This supports exception flush in later projects.
- MDU_CANCEL_EN not defined: no cancel port; every started op always commits.

## Test plan
- Reset then mult with rs=0xFFFFFFFF (-1), rt=2 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1.
- divu rt=0 after mthi 0x12345678 -> busy for 10 cycles, then hi still 0x12345678 and lo unchanged.
- mult issued with d_md_use=1 (mflo in D) -> md_stall=1 from the start cycle through the last busy cycle, then 0; mflo then reads the product.
- mtlo 0xCAFEBABE -> lo=0xCAFEBABE next cycle, busy never 1; start of div during BUSY -> ignored, result is that of the first op.
- reset pulsed low in the 3rd busy cycle of a mult -> busy=0, hi=lo=0 immediately. With MDU_CANCEL_EN, cancel on the cnt==1 cycle -> no commit.
